inst_queue: RTL
===============

Name: inst_queue

Overview:
- Instruction fetch buffer between the I-cache data return and decode.
- Accepts one 64-bit fetch packet per cycle: two 32-bit instructions with a per-slot valid mask and a fetch-exception flag. Writes the valid slots, compacted and in order, into a circular register queue.
- Presents the two oldest instructions to decode, which may consume 0, 1 or 2 per cycle.
- A pipeline flush (branch redirect or exception) empties the queue in one cycle.

Parameters:
- DEPTH, 16, number of 32-bit instruction entries; power of two, at least 4.
- PTR_W, $clog2(DEPTH), pointer width; derived, not overridden.

Ports:
- clk_g  input  1  clock, all state on rising edge
- rst  input  1  synchronous, active-high reset
- flush  input  1  discard all entries this cycle
- in_valid  input  1  fetch packet present (driven by I-cache data_ok)
- in_ready  output  1  queue can accept a full packet
- in_pc  input  32  8-byte-aligned base PC of the packet
- in_data  input  64  [31:0] = instruction at in_pc, [63:32] = instruction at in_pc+4
- in_mask  input  2  per-slot valid; bit0 = low word, bit1 = high word
- in_ex  input  1  fetch exception (TLB or address error) for this packet
- out_valid  output  2  bit0: slot0 valid; bit1: slot1 valid
- out_pc0, out_pc1  output  32 each  PCs of oldest and second-oldest entries
- out_inst0, out_inst1  output  32 each  instructions of those entries
- out_ex0, out_ex1  output  1 each  exception flags of those entries
- deq_num  input  2  number of entries decode consumes this cycle (0..2)
- count  output  PTR_W+1  current occupancy

Behaviour:
- Storage: DEPTH registers of {pc[31:0], inst[31:0], ex}. head and tail are PTR_W bits and wrap modulo DEPTH. count is PTR_W+1 bits.
- Reset (rst=1 at a clock edge): head=tail=count=0, out_valid=2'b00, in_ready=1. Data registers are not reset; outputs derived from them are don't-care while the matching out_valid bit is 0.
- in_ready = (count <= DEPTH-2), from registered count only. It does not depend on deq_num in the same cycle (no combinational path decode -> fetch).
- Accept = in_valid && in_ready && !flush.
- push_n = popcount(in_mask), range 0..2. in_mask=0 with in_valid is legal and pushes nothing.
- Enqueue compaction:
  - mask 11: entry[tail]={in_pc, in_data[31:0], in_ex}; entry[tail+1]={in_pc+4, in_data[63:32], in_ex}.
  - mask 01: only entry[tail] from the low word.
  - mask 10: entry[tail]={in_pc+4, in_data[63:32], in_ex}.
  - tail += push_n.
- Output is combinational from registers:
  - out_valid[0] = (count>=1); out_valid[1] = (count>=2).
  - slot0 = entry[head]; slot1 = entry[head+1] (wraps).
  - Latency from accepted push to visible at output: 1 cycle.
- Dequeue: pop_n = min(deq_num, count); head += pop_n. deq_num > count is a protocol error and must be flagged by a simulation-only assertion; hardware saturates.
- Push and pop in the same cycle: count_next = count + push_n - pop_n. Entries popped and pushed in one cycle never alias, because in_ready guarantees 2 free slots.
- Full boundary: count = DEPTH-1 gives in_ready=0 even for a single-slot packet (conservative). count = DEPTH is reachable only via a 2-slot push at DEPTH-2.
- Flush: highest priority. Next cycle head=tail=count=0 and out_valid=0. Push and pop in the same cycle are ignored.
- rst takes precedence over flush, and both override in-flight push/pop.

Optional Feature:
- Macro: INST_QUEUE_PERF_EN
- Defined: adds output ports perf_full_cycles[31:0] and perf_empty_cycles[31:0].
  - perf_full_cycles increments on each cycle with in_valid=1 and in_ready=0.
  - perf_empty_cycles increments on each cycle with count=0 and no flush.
  - Both counters wrap at 2^32, clear on rst, and are not cleared by flush.
- Undefined: ports and counters are absent; all other behaviour is identical.

Test Plan:
- Reset, then idle -> in_ready=1, out_valid=00, count=0 for 5 cycles.
- Push pc=0xBFC00000, data=0x24020002_24010001, mask=11; deq_num=0 -> next cycle out_valid=11, out_pc0=0xBFC00000, out_inst0=0x24010001, out_pc1=0xBFC00004, out_inst1=0x24020002, count=2.
- Push pc=0x80001000, mask=10, data high=0x1000FFFF, in_ex=1 into empty queue -> out_valid=01, out_pc0=0x80001004, out_inst0=0x1000FFFF, out_ex0=1.
- Fill with eight mask=11 packets (DEPTH=16), deq_num=0 -> count=16, in_ready=0. Then deq_num=2 for one cycle -> count=14, in_ready=1 next cycle. Repeat until the pointers wrap; PCs must emerge in order.
- With count=6, assert flush together with in_valid (mask=11) and deq_num=2 -> next cycle count=0, out_valid=00; the flushed-cycle packet does not appear.
- Steady state: push mask=11 and deq_num=2 every cycle for 40 cycles -> count constant at 2, output PC sequence strictly +4. With INST_QUEUE_PERF_EN, perf_full_cycles=0 and perf_empty_cycles=1 (first cycle only).

Source files
------------

// File: rtl/inst_queue.sv
// inst_queue: instruction fetch buffer between the I-cache data return and decode.
// Accepts one 2-slot fetch packet per cycle, compacts valid slots into a circular
// queue and presents the two oldest entries to decode.
// Optional feature macro: INST_QUEUE_PERF_EN (adds perf_full_cycles / perf_empty_cycles).
module inst_queue #(
    parameter int unsigned  DEPTH = 16,
    localparam int unsigned PTR_W = $clog2(DEPTH)
) (
    input  logic             clk_g,
    input  logic             rst,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      in_pc,
    input  logic [63:0]      in_data,
    input  logic [1:0]       in_mask,
    input  logic             in_ex,
    output logic [1:0]       out_valid,
    output logic [31:0]      out_pc0,
    output logic [31:0]      out_pc1,
    output logic [31:0]      out_inst0,
    output logic [31:0]      out_inst1,
    output logic             out_ex0,
    output logic             out_ex1,
    input  logic [1:0]       deq_num,
`ifdef INST_QUEUE_PERF_EN
    output logic [31:0]      perf_full_cycles,
    output logic [31:0]      perf_empty_cycles,
`endif
    output logic [PTR_W:0]   count
);

    // Highest occupancy at which a full 2-slot packet still fits.
    localparam logic [PTR_W:0] READY_MAX = (PTR_W + 1)'(DEPTH - 2);

    logic [31:0]      pc_q   [DEPTH];
    logic [31:0]      inst_q [DEPTH];
    logic             ex_q   [DEPTH];

    logic [PTR_W-1:0] head_q, head_d;
    logic [PTR_W-1:0] tail_q, tail_d;
    logic [PTR_W:0]   count_q, count_d;

    logic             accept;
    logic [1:0]       push_n;
    logic [1:0]       pop_n;
    logic [PTR_W:0]   deq_ext;
    logic [PTR_W-1:0] head_p1;
    logic [PTR_W-1:0] tail_p1;
    logic [31:0]      wr0_pc;
    logic [31:0]      wr0_inst;

    assign in_ready = (count_q <= READY_MAX);
    assign accept   = in_valid && in_ready && !flush;
    assign push_n   = {1'b0, in_mask[0]} + {1'b0, in_mask[1]};
    assign deq_ext  = (PTR_W + 1)'(deq_num);
    // Saturate: when deq_num exceeds occupancy, occupancy is below 3 so its low bits suffice.
    assign pop_n    = (deq_ext <= count_q) ? deq_num : count_q[1:0];

    assign head_p1  = head_q + PTR_W'(1);
    assign tail_p1  = tail_q + PTR_W'(1);

    // The first written slot takes the low word unless only the high word is valid.
    assign wr0_pc   = in_mask[0] ? in_pc : in_pc + 32'd4;
    assign wr0_inst = in_mask[0] ? in_data[31:0] : in_data[63:32];

    // Next-state pointers and occupancy; flush discards push and pop.
    always_comb begin
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;
        if (flush) begin
            head_d  = '0;
            tail_d  = '0;
            count_d = '0;
        end else begin
            head_d  = head_q + PTR_W'(pop_n);
            if (accept) begin
                tail_d = tail_q + PTR_W'(push_n);
            end
            count_d = count_q + (PTR_W + 1)'(accept ? push_n : 2'd0) - (PTR_W + 1)'(pop_n);
        end
    end

    // Pointer and occupancy registers with synchronous reset.
    always_ff @(posedge clk_g) begin
        if (rst) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end

    // Entry storage writes; the data array is intentionally left unreset.
    always_ff @(posedge clk_g) begin
        if (accept && !rst) begin
            if (push_n != 2'd0) begin
                pc_q[tail_q]   <= wr0_pc;
                inst_q[tail_q] <= wr0_inst;
                ex_q[tail_q]   <= in_ex;
            end
            if (in_mask == 2'b11) begin
                pc_q[tail_p1]   <= in_pc + 32'd4;
                inst_q[tail_p1] <= in_data[63:32];
                ex_q[tail_p1]   <= in_ex;
            end
        end
    end

    assign out_valid = {count_q >= (PTR_W + 1)'(2), count_q != '0};
    assign out_pc0   = pc_q[head_q];
    assign out_inst0 = inst_q[head_q];
    assign out_ex0   = ex_q[head_q];
    assign out_pc1   = pc_q[head_p1];
    assign out_inst1 = inst_q[head_p1];
    assign out_ex1   = ex_q[head_p1];
    assign count     = count_q;

`ifdef INST_QUEUE_PERF_EN
    logic [31:0] perf_full_q;
    logic [31:0] perf_empty_q;

    // Stall and starvation counters; survive flush, cleared only by reset.
    always_ff @(posedge clk_g) begin
        if (rst) begin
            perf_full_q  <= '0;
            perf_empty_q <= '0;
        end else begin
            if (in_valid && !in_ready) begin
                perf_full_q <= perf_full_q + 32'd1;
            end
            if ((count_q == '0) && !flush) begin
                perf_empty_q <= perf_empty_q + 32'd1;
            end
        end
    end

    assign perf_full_cycles  = perf_full_q;
    assign perf_empty_cycles = perf_empty_q;
`endif

`ifndef SYNTHESIS
    // Decode must never ask for more entries than are present.
    a_deq_within_count: assert property (@(posedge clk_g) disable iff (rst || flush)
        deq_ext <= count_q);
    a_deq_range: assert property (@(posedge clk_g) disable iff (rst)
        deq_num != 2'd3);
`endif

endmodule
